exc_sequencer: RTL and testbench
================================

# exc_sequencer

Parametrised exception sequencer that takes over from the main control FSM whenever an exception is raised (overflow, divide-by-zero, invalid opcode, or further sources). It saves the faulting PC into EPC and fetches the handler address byte from a vector table in memory. It then loads PC and hands control back with an acknowledge pulse. It also services the return-from-exception path (PC restored from EPC). It sits between the control unit, PC/EPC registers and the memory port mux.

## Interface
- NUM_EXC, 3, number of exception sources; index 0 = highest priority (1..8)
- ADDR_W, 32, PC/EPC/memory address width
- VEC_BASE, 253, vector-table address of source 0; source k at VEC_BASE+k
- MEM_LAT, 1, memory read latency in cycles (≥1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- exc_req  in  NUM_EXC  exception request levels, sampled in IDLE
- rte  in  1  return-from-exception request, sampled in IDLE
- pc_in  in  ADDR_W  current (already incremented) PC
- mem_rdata  in  8  vector byte from memory
- busy  out  1  high in every state except IDLE
- exc_ack  out  1  one-cycle pulse when handler PC has been loaded
- cause_out  out  3  index of last serviced source (registered)
- epc_out  out  ADDR_W  EPC register contents
- epc_write  out  1  EPC being written this cycle
- mem_addr  out  ADDR_W  vector-table read address
- mem_read  out  1  memory read strobe
- pc_out  out  ADDR_W  value to load into PC
- pc_write  out  1  PC load strobe

## Operation
- States: IDLE, SAVE, READ, LOAD, DONE, RET. Outputs are Moore decodes of state plus internal registers.
- IDLE:
  - If any exc_req bit is set, latch the lowest set index k into cause_out, then go to SAVE.
  - Else if rte = 1, go to RET.
  - exc_req wins over a simultaneous rte.
- SAVE:
  - epc_write = 1.
  - EPC register <= pc_in − 4, modulo 2^ADDR_W (pc_in = 0 gives all-ones−3).
  - Go to READ.
- READ:
  - mem_read = 1.
  - mem_addr = VEC_BASE + cause_out, modulo 2^ADDR_W.
  - Held for MEM_LAT cycles by an internal down-counter, then go to LOAD.
- LOAD:
  - mem_addr is still held; mem_read = 0.
  - pc_out = zero-extended mem_rdata; pc_write = 1.
  - Go to DONE.
- DONE: exc_ack = 1, then go to IDLE.
- RET: pc_out = EPC register; pc_write = 1; go to IDLE. exc_ack is not pulsed.
- exc_req changes and rte while busy are handled per Configuration.
- Reset values:
  - State IDLE; EPC, cause_out, counter and pending register all 0.
  - All strobes (epc_write, mem_read, pc_write, exc_ack, busy) 0.
  - mem_addr = 0, pc_out = 0.
- Reset (reset = 0) at any clock edge mid-sequence:
  - Abort to IDLE with reset values.
  - No further pc_write or epc_write.
  - Pending requests cleared.

## Timing
- Exception request at IDLE in cycle 0:
  - epc_write in cycle 1.
  - mem_read in cycles 2..1+MEM_LAT.
  - pc_write in cycle 2+MEM_LAT.
  - exc_ack in cycle 3+MEM_LAT.
  - IDLE again in cycle 4+MEM_LAT.
  - With MEM_LAT = 1: pc_write in cycle 3, ack in cycle 4.
- rte at IDLE in cycle 0: pc_write in cycle 1, IDLE in cycle 2.
- The earliest new acceptance is the cycle after DONE/RET.
- Strobes are single-cycle except mem_read, which lasts exactly MEM_LAT cycles.
- cause_out updates at the edge leaving IDLE and stays stable until the next acceptance.

## Configuration
- EXC_PENDING_EN defined:
  - exc_req bits that rise while busy are OR-ed into a NUM_EXC-bit pending register.
  - In IDLE, the sequencer services the highest-priority bit of (pending | exc_req) and clears that pending bit on acceptance.
  - Pending takes priority over rte.
- Undefined: requests and rte seen while busy are ignored; the source must hold them until IDLE.

## Test plan
- Single overflow, MEM_LAT = 1:
  - Stimulus: exc_req = 3'b001, pc_in = 0x40, mem_rdata = 0x7C.
  - Response: epc_out = 0x3C; mem_addr = 253 with mem_read in cycle 2; pc_out = 0x7C with pc_write in cycle 3; exc_ack in cycle 4; cause_out = 0.
- Priority:
  - Stimulus: exc_req = 3'b110.
  - Response: cause_out = 1; mem_addr = 254.
- Simultaneous request and rte:
  - Stimulus: exc_req = 3'b100 and rte = 1 in the same cycle.
  - Response: exception serviced (mem_addr = 255); no RET pc_write of EPC.
- Return path:
  - Stimulus: after the first test, rte = 1.
  - Response: pc_out = 0x3C with pc_write next cycle; busy low after 2 cycles.
- Edge cases:
  - Stimulus: reset = 0 during READ; separately, MEM_LAT = 3 with pc_in = 0.
  - Response: reset gives immediate IDLE, all outputs 0, no pc_write afterwards. MEM_LAT = 3 gives 3-cycle mem_read and epc_out = 0xFFFFFFFC.
- With EXC_PENDING_EN:
  - Stimulus: exc_req bit 2 pulses during READ of a bit-0 service.
  - Response: second sequence starts the cycle after DONE with cause_out = 2.
  - Without EXC_PENDING_EN: no second sequence.

Source files
------------

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - exception entry/return sequencer: EPC save, vector fetch, PC load.
// Optional build macro EXC_PENDING_EN: latch requests that rise while busy and service them afterwards.
module exc_sequencer #(
  parameter int NUM_EXC  = 3,
  parameter int ADDR_W   = 32,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic               rte,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [7:0]         mem_rdata,
  output logic               busy,
  output logic               exc_ack,
  output logic [2:0]         cause_out,
  output logic [ADDR_W-1:0]  epc_out,
  output logic               epc_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               pc_write
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    READ,
    LOAD,
    DONE,
    RET
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cause_q;
  logic [ADDR_W-1:0]  epc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_EXC-1:0] req_vec;
  logic               any_req;
  logic [2:0]         sel_idx;
  logic [ADDR_W-1:0]  vec_addr;

`ifdef EXC_PENDING_EN
  logic [NUM_EXC-1:0] pending_q, pending_d, exc_req_q;

  assign req_vec = pending_q | exc_req;

  // Only rising edges while busy are remembered, so a source still holding
  // the request being serviced does not get serviced twice.
  always_comb begin
    pending_d = pending_q | (exc_req & ~exc_req_q & {NUM_EXC{busy}});
    if (state_q == IDLE && any_req) begin
      pending_d = pending_d & ~(NUM_EXC'(1) << sel_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      exc_req_q <= '0;
    end else begin
      pending_q <= pending_d;
      exc_req_q <= exc_req;
    end
  end
`else
  assign req_vec = exc_req;
`endif

  // Lowest set index wins.
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        any_req = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end

  assign vec_addr  = ADDR_W'(VEC_BASE) + ADDR_W'(cause_q);
  assign cause_out = cause_q;
  assign epc_out   = epc_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    epc_write = 1'b0;
    mem_read  = 1'b0;
    pc_write  = 1'b0;
    exc_ack   = 1'b0;
    mem_addr  = '0;
    pc_out    = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_d = SAVE;
        end else if (rte) begin
          state_d = RET;
        end
      end
      SAVE: begin
        epc_write = 1'b1;
        state_d   = READ;
      end
      READ: begin
        mem_read = 1'b1;
        mem_addr = vec_addr;
        if (cnt_q == '0) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        mem_addr = vec_addr;
        pc_out   = ADDR_W'(mem_rdata);
        pc_write = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        exc_ack = 1'b1;
        state_d = IDLE;
      end
      RET: begin
        pc_out   = epc_q;
        pc_write = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        cause_q <= sel_idx;
      end
      if (state_q == SAVE) begin
        epc_q <= pc_in - ADDR_W'(4);
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if (state_q == READ && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - directed self-checking bench for exc_sequencer (MEM_LAT 1 and 3 instances).
module tb_exc_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  exc_req, exc_req3;
  logic        rte, rte3;
  logic [31:0] pc_in, pc_in3;
  logic [7:0]  mem_rdata;

  logic        busy, exc_ack, epc_write, mem_read, pc_write;
  logic [2:0]  cause_out;
  logic [31:0] epc_out, mem_addr, pc_out;

  logic        busy3, exc_ack3, epc_write3, mem_read3, pc_write3;
  logic [2:0]  cause_out3;
  logic [31:0] epc_out3, mem_addr3, pc_out3;

  int n_checks = 0;
  int n_fail   = 0;

  exc_sequencer #(.NUM_EXC(3), .ADDR_W(32), .VEC_BASE(253), .MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset), .exc_req(exc_req), .rte(rte), .pc_in(pc_in),
    .mem_rdata(mem_rdata), .busy(busy), .exc_ack(exc_ack), .cause_out(cause_out),
    .epc_out(epc_out), .epc_write(epc_write), .mem_addr(mem_addr), .mem_read(mem_read),
    .pc_out(pc_out), .pc_write(pc_write)
  );

  exc_sequencer #(.NUM_EXC(3), .ADDR_W(32), .VEC_BASE(253), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .exc_req(exc_req3), .rte(rte3), .pc_in(pc_in3),
    .mem_rdata(mem_rdata), .busy(busy3), .exc_ack(exc_ack3), .cause_out(cause_out3),
    .epc_out(epc_out3), .epc_write(epc_write3), .mem_addr(mem_addr3), .mem_read(mem_read3),
    .pc_out(pc_out3), .pc_write(pc_write3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", exc_ack); end
    n_checks++; if (epc_write !== 1'b0) begin n_fail++; $display("FAIL reset_epc_write: got %b expected 0", epc_write); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL reset_pc_write: got %b expected 0", pc_write); end
    n_checks++; if (cause_out !== 3'd0) begin n_fail++; $display("FAIL reset_cause: got %0d expected 0", cause_out); end
    n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", epc_out); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy3: got %b expected 0", busy3); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_overflow();
    pc_in = 32'h40; mem_rdata = 8'h7C; exc_req = 3'b001;
    @(negedge clk); // cycle 1
    exc_req = 3'b000;
    n_checks++; if (epc_write !== 1'b1) begin n_fail++; $display("FAIL ovf_epc_write_c1: got %b expected 1", epc_write); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_c1: got %b expected 1", busy); end
    @(negedge clk); // cycle 2
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ovf_mem_read_c2: got %b expected 1", mem_read); end
    n_checks++; if (mem_addr !== 32'd253) begin n_fail++; $display("FAIL ovf_mem_addr_c2: got %0d expected 253", mem_addr); end
    n_checks++; if (epc_out !== 32'h3C) begin n_fail++; $display("FAIL ovf_epc: got %h expected 3c", epc_out); end
    n_checks++; if (epc_write !== 1'b0) begin n_fail++; $display("FAIL ovf_epc_write_c2: got %b expected 0", epc_write); end
    @(negedge clk); // cycle 3
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL ovf_pc_write_c3: got %b expected 1", pc_write); end
    n_checks++; if (pc_out !== 32'h7C) begin n_fail++; $display("FAIL ovf_pc_out_c3: got %h expected 7c", pc_out); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL ovf_mem_read_c3: got %b expected 0", mem_read); end
    n_checks++; if (mem_addr !== 32'd253) begin n_fail++; $display("FAIL ovf_mem_addr_c3: got %0d expected 253", mem_addr); end
    @(negedge clk); // cycle 4
    n_checks++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL ovf_ack_c4: got %b expected 1", exc_ack); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL ovf_pc_write_c4: got %b expected 0", pc_write); end
    @(negedge clk); // cycle 5
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_c5: got %b expected 0", busy); end
    n_checks++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL ovf_ack_c5: got %b expected 0", exc_ack); end
    n_checks++; if (cause_out !== 3'd0) begin n_fail++; $display("FAIL ovf_cause: got %0d expected 0", cause_out); end
  endtask

  task automatic test_return();
    rte = 1'b1;
    @(negedge clk); // cycle 1
    rte = 1'b0;
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rte_pc_write: got %b expected 1", pc_write); end
    n_checks++; if (pc_out !== 32'h3C) begin n_fail++; $display("FAIL rte_pc_out: got %h expected 3c", pc_out); end
    n_checks++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL rte_ack: got %b expected 0", exc_ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rte_busy_c1: got %b expected 1", busy); end
    @(negedge clk); // cycle 2
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rte_busy_c2: got %b expected 0", busy); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rte_pc_write_c2: got %b expected 0", pc_write); end
  endtask

  task automatic test_priority();
    exc_req = 3'b110;
    @(negedge clk); // cycle 1
    exc_req = 3'b000;
    n_checks++; if (cause_out !== 3'd1) begin n_fail++; $display("FAIL prio_cause: got %0d expected 1", cause_out); end
    @(negedge clk); // cycle 2
    n_checks++; if (mem_addr !== 32'd254) begin n_fail++; $display("FAIL prio_mem_addr: got %0d expected 254", mem_addr); end
    repeat (2) @(negedge clk); // cycle 4
    n_checks++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL prio_ack: got %b expected 1", exc_ack); end
    @(negedge clk); // cycle 5
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b expected 0", busy); end
  endtask

  task automatic test_simultaneous();
    pc_in = 32'h100; mem_rdata = 8'h55; exc_req = 3'b100; rte = 1'b1;
    @(negedge clk); // cycle 1
    exc_req = 3'b000; rte = 1'b0;
    n_checks++; if (epc_write !== 1'b1) begin n_fail++; $display("FAIL simul_epc_write: got %b expected 1", epc_write); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL simul_no_ret: got %b expected 0", pc_write); end
    @(negedge clk); // cycle 2
    n_checks++; if (mem_addr !== 32'd255) begin n_fail++; $display("FAIL simul_mem_addr: got %0d expected 255", mem_addr); end
    n_checks++; if (cause_out !== 3'd2) begin n_fail++; $display("FAIL simul_cause: got %0d expected 2", cause_out); end
    @(negedge clk); // cycle 3
    n_checks++; if (pc_out !== 32'h55) begin n_fail++; $display("FAIL simul_pc_out: got %h expected 55", pc_out); end
    repeat (2) @(negedge clk); // cycle 5
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got %b expected 0", busy); end
    n_checks++; if (epc_out !== 32'hFC) begin n_fail++; $display("FAIL simul_epc: got %h expected fc", epc_out); end
  endtask

  task automatic test_reset_mid();
    int stray;
    pc_in = 32'h40; exc_req = 3'b001;
    @(negedge clk); // cycle 1
    exc_req = 3'b000;
    @(negedge clk); // cycle 2 (READ)
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_read: got %b expected 1", mem_read); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_pc_write: got %b expected 0", pc_write); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_epc: got %h expected 0", epc_out); end
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_write || epc_write || busy) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rstmid_stray_strobes: got %0d expected 0", stray); end
  endtask

  task automatic test_mem_lat3();
    int reads;
    pc_in3 = 32'h0; mem_rdata = 8'h7C; exc_req3 = 3'b001;
    @(negedge clk); // cycle 1
    exc_req3 = 3'b000;
    n_checks++; if (epc_write3 !== 1'b1) begin n_fail++; $display("FAIL lat3_epc_write: got %b expected 1", epc_write3); end
    reads = 0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (mem_read3 === 1'b1) reads++;
      if (c == 2) begin
        n_checks++; if (epc_out3 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL lat3_epc: got %h expected fffffffc", epc_out3); end
      end
    end
    @(negedge clk); // cycle 5
    if (mem_read3 === 1'b1) reads++;
    n_checks++; if (reads !== 3) begin n_fail++; $display("FAIL lat3_read_cycles: got %0d expected 3", reads); end
    n_checks++; if (pc_write3 !== 1'b1) begin n_fail++; $display("FAIL lat3_pc_write_c5: got %b expected 1", pc_write3); end
    @(negedge clk); // cycle 6
    n_checks++; if (exc_ack3 !== 1'b1) begin n_fail++; $display("FAIL lat3_ack_c6: got %b expected 1", exc_ack3); end
    @(negedge clk); // cycle 7
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL lat3_idle_c7: got %b expected 0", busy3); end
  endtask

  task automatic test_pending();
    int guard;
    pc_in = 32'h200; exc_req = 3'b001;
    @(negedge clk); // cycle 1
    exc_req = 3'b000;
    @(negedge clk); // cycle 2 (READ)
    exc_req = 3'b100;
    @(negedge clk); // cycle 3
    exc_req = 3'b000;
    @(negedge clk); // cycle 4
    n_checks++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL pend_first_ack: got %b expected 1", exc_ack); end
    repeat (2) @(negedge clk); // cycle 6
`ifdef EXC_PENDING_EN
    n_checks++; if (epc_write !== 1'b1) begin n_fail++; $display("FAIL pend_second_seq: got %b expected 1", epc_write); end
    n_checks++; if (cause_out !== 3'd2) begin n_fail++; $display("FAIL pend_cause: got %0d expected 2", cause_out); end
`else
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_ignored: got %b expected 0", busy); end
    n_checks++; if (cause_out !== 3'd0) begin n_fail++; $display("FAIL pend_cause: got %0d expected 0", cause_out); end
`endif
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_drain_timeout: got %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b0; exc_req = '0; exc_req3 = '0; rte = 1'b0; rte3 = 1'b0;
    pc_in = '0; pc_in3 = '0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_single_overflow();
    test_return();
    test_priority();
    test_simultaneous();
    test_reset_mid();
    test_mem_lat3();
    test_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
